// File: rtl/emisor_pkg.sv
// Shared definitions for the emisor serial transmitter and its link partner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package emisor_pkg;

    // Default word length; the receiver instantiation uses it too so both ends agree.
    localparam int DEFAULT_WIDTH = 16;

    // Transmitter FSM states. The S_ prefix keeps the literals clear of the GAP parameter.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/emisor.sv
// Serial transmitter: takes a parallel word on load/ready and shifts it out MSB first.
// Latency: first bit and enable_out appear one cycle after acceptance; frame period WIDTH+GAP+1.
// Backpressure: ready is low during SHIFT and GAP, and load is ignored while ready is low.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   data_in    parallel word, captured when load && ready
//   load       valid for data_in
//   ready      idle, a word can be accepted
//   signal_out serial data, MSB first (to receiver signal_in)
//   enable_out high for exactly WIDTH cycles per frame (to receiver enable)
//   tx_done    one-cycle pulse as the frame finishes
module emisor
    import emisor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GAP   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             signal_out,
    output logic             enable_out,
    output logic             tx_done
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = $clog2(GAP + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [BW-1:0]    r_bcnt;
    logic [GW-1:0]    r_gcnt;
    logic             r_ready;
    logic             r_signal;
    logic             r_enable;
    logic             r_done;

    state_t           w_state;
    logic [WIDTH-1:0] w_sreg;
    logic [BW-1:0]    w_bcnt;
    logic [GW-1:0]    w_gcnt;
    logic             w_ready;
    logic             w_signal;
    logic             w_enable;
    logic             w_done;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_sreg   <= '0;
            r_bcnt   <= '0;
            r_gcnt   <= '0;
            r_ready  <= 1'b1;
            r_signal <= 1'b0;
            r_enable <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_sreg   <= w_sreg;
            r_bcnt   <= w_bcnt;
            r_gcnt   <= w_gcnt;
            r_ready  <= w_ready;
            r_signal <= w_signal;
            r_enable <= w_enable;
            r_done   <= w_done;
        end
    end

    // Next-state and next-output logic. signal_out, enable_out and tx_done default
    // low so they are only raised in the cycles that explicitly drive them.
    always_comb begin
        w_state  = r_state;
        w_sreg   = r_sreg;
        w_bcnt   = r_bcnt;
        w_gcnt   = r_gcnt;
        w_ready  = r_ready;
        w_signal = 1'b0;
        w_enable = 1'b0;
        w_done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (load) begin
                    // The MSB goes straight to the output, so the register keeps
                    // only the remaining WIDTH-1 bits, left-aligned.
                    w_signal = data_in[WIDTH-1];
                    w_enable = 1'b1;
                    w_sreg   = {data_in[WIDTH-2:0], 1'b0};
                    w_bcnt   = BW'(WIDTH - 1);
                    w_ready  = 1'b0;
                    w_state  = S_SHIFT;
                end
            end

            S_SHIFT: begin
                w_ready = 1'b0;
                if (r_bcnt != '0) begin
                    w_signal = r_sreg[WIDTH-1];
                    w_enable = 1'b1;
                    w_sreg   = {r_sreg[WIDTH-2:0], 1'b0};
                    w_bcnt   = r_bcnt - BW'(1);
                end else begin
                    // Last bit has already been on the line for one cycle.
                    w_done  = 1'b1;
                    w_gcnt  = GW'(GAP - 1);
                    w_state = S_GAP;
                end
            end

            S_GAP: begin
                w_ready = 1'b0;
                if (r_gcnt == '0) begin
                    w_ready = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_gcnt = r_gcnt - GW'(1);
                end
            end

            default: begin
                w_ready = 1'b1;
                w_state = S_IDLE;
            end
        endcase
    end

    assign ready      = r_ready;
    assign signal_out = r_signal;
    assign enable_out = r_enable;
    assign tx_done    = r_done;

endmodule

// File: tb/tb_emisor.sv
// Directed bench for emisor: a 16-bit/GAP=2 instance with a receiver model on its
// serial outputs, plus an 8-bit/GAP=1 instance for the parameter corner.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_emisor;

    logic        clk;
    logic        RST;
    logic [15:0] data_in;
    logic        load;
    logic        ready;
    logic        signal_out;
    logic        enable_out;
    logic        tx_done;

    logic [7:0]  data8;
    logic        load8;
    logic        ready8;
    logic        sig8;
    logic        en8;
    logic        done8;

    int n_cmp = 0;
    int n_err = 0;

    emisor #(.WIDTH(16), .GAP(2)) u_dut (
        .CLK        (clk),
        .RST        (RST),
        .data_in    (data_in),
        .load       (load),
        .ready      (ready),
        .signal_out (signal_out),
        .enable_out (enable_out),
        .tx_done    (tx_done)
    );

    emisor #(.WIDTH(8), .GAP(1)) u_dut8 (
        .CLK        (clk),
        .RST        (RST),
        .data_in    (data8),
        .load       (load8),
        .ready      (ready8),
        .signal_out (sig8),
        .enable_out (en8),
        .tx_done    (done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver model: left shift while enabled, copy to the parallel output on
    // the first edge that sees enable low after a frame.
    logic [15:0] rx_sreg = '0;
    logic [15:0] rx_out  = '0;
    logic        rx_en_d = 1'b0;
    always @(posedge clk) begin
        if (enable_out) rx_sreg <= {rx_sreg[14:0], signal_out};
        if (!enable_out && rx_en_d) rx_out <= rx_sreg;
        rx_en_d <= enable_out;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends one 16-bit word and checks the whole frame against fixed timing.
    // With busy_pulse set, a BEEF load is pulsed in the middle of SHIFT.
    task automatic tx16(input logic [15:0] word, input bit busy_pulse);
        logic [15:0] bits;
        int en_cnt;
        int rdy_hi;
        @(negedge clk);
        data_in = word;
        load    = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        bits   = '0;
        en_cnt = 0;
        rdy_hi = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            bits = {bits[14:0], signal_out};
            if (enable_out) en_cnt++;
            if (ready) rdy_hi++;
            if (busy_pulse && i == 5) begin
                data_in = 16'hBEEF;
                load    = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        @(negedge clk);
        chk("end_en_low", enable_out, 0);
        chk("end_done", tx_done, 1);
        chk("end_sig_low", signal_out, 0);
        @(negedge clk);
        chk("gap_done_clr", tx_done, 0);
        chk("gap_ready_low", ready, 0);
        chk("rx_word", rx_out, word);
        @(negedge clk);
        chk("ready_back", ready, 1);
        chk("bits", bits, word);
        chk("en_cycles", en_cnt, 16);
        chk("busy_ready", rdy_hi, 0);
    endtask

    initial begin
        logic [15:0] w1;
        logic [15:0] w2;
        logic [7:0]  bits8;
        int          low_cnt;
        int          en_cnt;
        int          done_cnt;

        RST     = 1'b1;
        load    = 1'b0;
        data_in = '0;
        load8   = 1'b0;
        data8   = '0;

        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_sig", signal_out, 0);
        chk("rst_en", enable_out, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_ready8", ready8, 1);

        // Reset and load together: nothing is captured.
        load    = 1'b1;
        data_in = 16'hFFFF;
        @(negedge clk);
        chk("rstload_en", enable_out, 0);
        chk("rstload_ready", ready, 1);
        load = 1'b0;
        RST  = 1'b0;
        @(negedge clk);
        chk("rstload_idle", enable_out, 0);

        // Single frame and loopback.
        tx16(16'hA5C3, 1'b0);
        tx16(16'h1234, 1'b0);

        // Continuous load: FFFF then 0000, back to back.
        @(negedge clk);
        data_in = 16'hFFFF;
        load    = 1'b1;
        w1 = '0;
        w2 = '0;
        low_cnt = 0;
        for (int t = 0; t <= 40; t++) begin
            @(negedge clk);
            if (t == 0) data_in = 16'h0000;
            if (t < 16) w1 = {w1[14:0], signal_out};
            if (t >= 16 && t <= 18 && !enable_out) low_cnt++;
            if (t >= 19 && t < 35) w2 = {w2[14:0], signal_out};
            if (t == 17) chk("cont_rx1", rx_out, 16'hFFFF);
            if (t == 19) begin
                chk("cont_en2_start", enable_out, 1);
                load = 1'b0;
            end
            if (t == 36) chk("cont_rx2", rx_out, 16'h0000);
            if (t == 40) chk("cont_no_third", enable_out, 0);
        end
        chk("cont_w1", w1, 16'hFFFF);
        chk("cont_w2", w2, 16'h0000);
        chk("cont_gap_low", low_cnt, 3);

        // Load while busy is ignored.
        tx16(16'h00F0, 1'b1);
        en_cnt   = 0;
        done_cnt = 0;
        for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            if (enable_out) en_cnt++;
            if (tx_done) done_cnt++;
        end
        chk("busy_no_frame", en_cnt, 0);
        chk("busy_no_done", done_cnt, 0);
        chk("busy_rx", rx_out, 16'h00F0);

        // Reset mid-frame after bit 7 of A5C3.
        @(negedge clk);
        data_in = 16'hA5C3;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_en_before", enable_out, 1);
        RST = 1'b1;
        @(negedge clk);
        chk("mid_en", enable_out, 0);
        chk("mid_sig", signal_out, 0);
        chk("mid_done", tx_done, 0);
        RST = 1'b0;
        @(negedge clk);
        chk("mid_ready", ready, 1);
        chk("mid_idle_en", enable_out, 0);
        tx16(16'h5A5A, 1'b0);

        // Parameter corner: WIDTH=8, GAP=1, load held so the period shows up.
        @(negedge clk);
        data8 = 8'h81;
        load8 = 1'b1;
        bits8  = '0;
        en_cnt = 0;
        for (int t = 0; t <= 10; t++) begin
            @(negedge clk);
            if (t < 8) bits8 = {bits8[6:0], sig8};
            if (t < 10 && en8) en_cnt++;
            if (t == 7) chk("c8_en_last", en8, 1);
            if (t == 8) begin
                chk("c8_en_fall", en8, 0);
                chk("c8_done", done8, 1);
            end
            if (t == 9) begin
                chk("c8_ready", ready8, 1);
                chk("c8_en_gap", en8, 0);
            end
            if (t == 10) begin
                chk("c8_period", en8, 1);
                load8 = 1'b0;
            end
        end
        chk("c8_bits", bits8, 8'h81);
        chk("c8_en_cycles", en_cnt, 8);
        repeat (12) @(negedge clk);
        chk("c8_idle", ready8, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
